// File: rtl/sdp_ram_be_init.sv
// sdp_ram_be_init
//   Simple dual-port RAM (one write port, one read port, single clock) with
//   per-byte write enables, a registered read with valid strobe, an optional
//   second output register and a hardware clear of every word to INIT_VAL
//   after reset.
//
// Optional feature macro: SDP_RAM_WR_BYPASS_EN
//   Defined   : same-edge read/write to the same in-range address returns
//               write-first data (enabled lanes take wd, others old contents).
//   Undefined : read-first; no bypass logic is built.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   init_busy  out  high in reset and while the clear sequence runs
//   we         in   write enable
//   be         in   byte-lane enables (NB = DWIDTH/BWIDTH)
//   wa         in   write address
//   wd         in   write data
//   re         in   read enable
//   ra         in   read address
//   rd         out  read data (holds between reads)
//   rd_valid   out  one-cycle strobe marking fresh rd
module sdp_ram_be_init #(
  parameter int unsigned          DWIDTH   = 16,
  parameter int unsigned          BWIDTH   = 8,
  parameter int unsigned          AWIDTH   = 4,
  parameter int unsigned          DEPTH    = 16,
  parameter int unsigned          OUT_REG  = 0,
  parameter logic [DWIDTH-1:0]    INIT_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       init_busy,
  input  logic                       we,
  input  logic [DWIDTH/BWIDTH-1:0]   be,
  input  logic [AWIDTH-1:0]          wa,
  input  logic [DWIDTH-1:0]          wd,
  input  logic                       re,
  input  logic [AWIDTH-1:0]          ra,
  output logic [DWIDTH-1:0]          rd,
  output logic                       rd_valid
);

  localparam int unsigned       NB       = DWIDTH / BWIDTH;
  localparam logic [AWIDTH:0]   LP_DEPTH = (AWIDTH + 1)'(DEPTH);
  localparam logic [AWIDTH-1:0] LP_LAST  = AWIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [AWIDTH-1:0]   r_cnt;
  logic                r_busy;
  logic [DWIDTH-1:0]   r_mem [DEPTH];

  logic                w_ready;
  logic                w_wr_ok;
  logic                w_rd_in_range;
  logic                w_rd_fire;
  logic [DWIDTH-1:0]   w_rd_word;
  logic [DWIDTH-1:0]   w_rd_data;

  logic [DWIDTH-1:0]   r_rd1;
  logic                r_v1;

  // ---------------------------------------------------------------------------
  // Clear-sequence FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT:  if (r_cnt == LP_LAST) w_state_nxt = ST_READY;
      ST_READY: w_state_nxt = ST_READY;
      default:  w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ST_INIT);
      if (r_state == ST_INIT) r_cnt <= r_cnt + AWIDTH'(1);
    end
  end

  assign init_busy = r_busy;

  // ---------------------------------------------------------------------------
  // Storage: clear writes own the port during INIT, user writes afterwards.
  // Out-of-range write addresses are dropped.
  // ---------------------------------------------------------------------------
  assign w_ready       = (r_state == ST_READY);
  assign w_wr_ok       = w_ready & we & ({1'b0, wa} < LP_DEPTH);
  assign w_rd_in_range = ({1'b0, ra} < LP_DEPTH);
  assign w_rd_fire     = w_ready & re;

  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_mem[r_cnt] <= INIT_VAL;
    end else if (w_wr_ok) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (be[i]) r_mem[wa][i*BWIDTH +: BWIDTH] <= wd[i*BWIDTH +: BWIDTH];
      end
    end
  end

  assign w_rd_word = w_rd_in_range ? r_mem[ra] : INIT_VAL;

`ifdef SDP_RAM_WR_BYPASS_EN
  // Write-first: merge the enabled lanes of the concurrent write into the
  // word being read so the result matches what the array will hold.
  always_comb begin
    w_rd_data = w_rd_word;
    if (w_wr_ok && (wa == ra)) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (be[i]) w_rd_data[i*BWIDTH +: BWIDTH] = wd[i*BWIDTH +: BWIDTH];
      end
    end
  end
`else
  always_comb begin
    w_rd_data = w_rd_word;
  end
`endif

  // ---------------------------------------------------------------------------
  // Read pipeline
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd1 <= '0;
      r_v1  <= 1'b0;
    end else begin
      r_v1 <= w_rd_fire;
      if (w_rd_fire) r_rd1 <= w_rd_data;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [DWIDTH-1:0] r_rd2;
    logic              r_v2;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rd2 <= '0;
        r_v2  <= 1'b0;
      end else begin
        r_v2 <= r_v1;
        if (r_v1) r_rd2 <= r_rd1;
      end
    end

    assign rd       = r_rd2;
    assign rd_valid = r_v2;
  end else begin : g_noreg
    assign rd       = r_rd1;
    assign rd_valid = r_v1;
  end

endmodule
